// File: rtl/pushbutton_pkg.sv
// Shared definitions for the pushbutton conditioner: debounce FSM state
// encoding and synchroniser depth.
package pushbutton_pkg;

  typedef enum logic [1:0] {
    S_REL  = 2'b00,
    S_PCHK = 2'b01,
    S_PRS  = 2'b11,
    S_RCHK = 2'b10
  } btn_state_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter and FSM that
// produces a clean level plus a one-cycle press pulse.
//
// state  | meaning
// S_REL  | released, waiting for a press
// S_PCHK | press seen, counting stable pressed cycles
// S_PRS  | pressed level committed
// S_RCHK | release seen, counting stable released cycles
module btn_debounce_ch
  import pushbutton_pkg::*;
#(
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic pulse,
  output logic pulse_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_q2;
  btn_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  level_nxt;

  assign sync_q2 = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      state  <= S_REL;
      cnt    <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], btn_in};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      pulse  <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    pulse_nxt = 1'b0;
    case (state)
      S_REL: begin
        if (sync_q2) begin
          state_nxt = S_PCHK;
          cnt_nxt   = '0;
        end
      end
      S_PCHK: begin
        if (!sync_q2) begin
          state_nxt = S_REL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_PRS;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PRS: begin
        if (!sync_q2) begin
          state_nxt = S_RCHK;
          cnt_nxt   = '0;
        end
      end
      S_RCHK: begin
        // a bounce back to pressed abandons the release without a new pulse
        if (sync_q2) begin
          state_nxt = S_PRS;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_REL;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_REL;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pushbutton_conditioner.sv
// Pushbutton conditioner feeding the processor pushbutton bus.
// Build option PB_STICKY_EN: bus carries sticky press flags acknowledged by rd_strobe.
module pushbutton_conditioner
  import pushbutton_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int DB_CYCLES  = 1000,
  parameter int CNT_W      = 10,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               rd_strobe,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] btn_event,
  output logic [NUM_BTN-1:0] pb_out
);

  logic [NUM_BTN-1:0] btn_pressed;
  logic [NUM_BTN-1:0] pulse_nxt;

  assign btn_pressed = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_pressed[i]),
      .level    (btn_level[i]),
      .pulse    (press_pulse[i]),
      .pulse_nxt(pulse_nxt[i])
    );
  end

`ifdef PB_STICKY_EN
  logic [NUM_BTN-1:0] event_q;

  // set wins over clear so a press landing on the acknowledge edge is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) event_q <= '0;
    else     event_q <= (event_q & ~{NUM_BTN{rd_strobe}}) | pulse_nxt;
  end

  assign btn_event = event_q;
  assign pb_out    = event_q;
`else
  logic unused_sticky;

  assign unused_sticky = ^{rd_strobe, pulse_nxt};
  assign btn_event     = '0;
  assign pb_out        = btn_level;
`endif

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed bench for pushbutton_conditioner with DB_CYCLES=4, NUM_BTN=4.
// Works in both builds (PB_STICKY_EN defined or not).
module tb_pushbutton_conditioner;

`ifdef PB_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'h0;
  logic       rd_strobe = 1'b0;
  logic [3:0] btn_level, press_pulse, btn_event, pb_out;

  int n_checks = 0;
  int n_fail   = 0;

  pushbutton_conditioner #(
    .NUM_BTN   (4),
    .DB_CYCLES (4),
    .CNT_W     (10),
    .ACTIVE_LOW(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .rd_strobe  (rd_strobe),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .btn_event  (btn_event),
    .pb_out     (pb_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_evt;
    exp_evt = STICKY ? 4'hF : 4'h0;
    rst = 1'b1; btn_raw = 4'hF;
    tick(3);
    n_checks++;
    if ({btn_level, press_pulse, btn_event, pb_out} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0000", {btn_level, press_pulse, btn_event, pb_out});
    end
    rst = 1'b0;
    tick(6);
    n_checks++;
    if (btn_level !== 4'h0) begin
      n_fail++; $display("FAIL reset_early_level: got %h, want 0", btn_level);
    end
    tick(1);
    n_checks++;
    if (btn_level !== 4'hF || press_pulse !== 4'hF) begin
      n_fail++; $display("FAIL reset_commit: level %h pulse %h, want F F", btn_level, press_pulse);
    end
    n_checks++;
    if (btn_event !== exp_evt || pb_out !== 4'hF) begin
      n_fail++; $display("FAIL reset_event: event %h pb %h, want %h F", btn_event, pb_out, exp_evt);
    end
    tick(1);
    n_checks++;
    if (press_pulse !== 4'h0 || btn_level !== 4'hF) begin
      n_fail++; $display("FAIL reset_pulse_width: pulse %h level %h, want 0 F", press_pulse, btn_level);
    end
    btn_raw = 4'h0;
    tick(7);
    n_checks++;
    if (btn_level !== 4'h0 || press_pulse !== 4'h0) begin
      n_fail++; $display("FAIL reset_release: level %h pulse %h, want 0 0", btn_level, press_pulse);
    end
    rd_strobe = 1'b1; tick(1); rd_strobe = 1'b0;
    n_checks++;
    if (btn_event !== 4'h0 || pb_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_ack: event %h pb %h, want 0 0", btn_event, pb_out);
    end
  endtask

  task automatic test_single_press;
    logic [3:0] exp_evt;
    exp_evt = STICKY ? 4'h1 : 4'h0;
    btn_raw = 4'h1;
    tick(6);
    n_checks++;
    if (btn_level !== 4'h0 || press_pulse !== 4'h0) begin
      n_fail++; $display("FAIL press_early: level %h pulse %h, want 0 0", btn_level, press_pulse);
    end
    tick(1);
    n_checks++;
    if (btn_level !== 4'h1 || press_pulse !== 4'h1) begin
      n_fail++; $display("FAIL press_commit: level %h pulse %h, want 1 1", btn_level, press_pulse);
    end
    n_checks++;
    if (btn_event !== exp_evt || pb_out !== 4'h1) begin
      n_fail++; $display("FAIL press_event: event %h pb %h, want %h 1", btn_event, pb_out, exp_evt);
    end
    tick(1);
    n_checks++;
    if (press_pulse !== 4'h0 || btn_level !== 4'h1) begin
      n_fail++; $display("FAIL press_pulse_width: pulse %h level %h, want 0 1", press_pulse, btn_level);
    end
  endtask

  task automatic test_glitch;
    btn_raw = 4'h3;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) btn_raw = 4'h1;
      tick(1);
      n_checks++;
      if ({btn_level[1], press_pulse[1], btn_event[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch_ch1 cycle %0d: level/pulse/event %b, want 000", i,
                 {btn_level[1], press_pulse[1], btn_event[1]});
      end
    end
    n_checks++;
    if (btn_level !== 4'h1) begin
      n_fail++; $display("FAIL glitch_other: level %h, want 1", btn_level);
    end
  endtask

  task automatic test_sticky_ack;
    logic [3:0] exp_evt;
    btn_raw = 4'h5;
    tick(7);
    exp_evt = STICKY ? 4'h5 : 4'h0;
    n_checks++;
    if (btn_level !== 4'h5 || btn_event !== exp_evt) begin
      n_fail++; $display("FAIL ack_press: level %h event %h, want 5 %h", btn_level, btn_event, exp_evt);
    end
    rd_strobe = 1'b1; tick(1); rd_strobe = 1'b0;
    n_checks++;
    if (btn_event !== 4'h0 || pb_out !== (STICKY ? 4'h0 : 4'h5)) begin
      n_fail++; $display("FAIL ack_clear: event %h pb %h", btn_event, pb_out);
    end
    btn_raw = 4'h1;
    tick(7);
    n_checks++;
    if (btn_level !== 4'h1) begin
      n_fail++; $display("FAIL ack_release: level %h, want 1", btn_level);
    end
    btn_raw = 4'h5;
    tick(6);
    rd_strobe = 1'b1; tick(1); rd_strobe = 1'b0;
    exp_evt = STICKY ? 4'h4 : 4'h0;
    n_checks++;
    if (press_pulse !== 4'h4 || btn_event !== exp_evt || pb_out[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_collide: pulse %h event %h pb %h, want 4 %h pb[2]=1", press_pulse, btn_event, pb_out, exp_evt);
    end
    rd_strobe = 1'b1; tick(1); rd_strobe = 1'b0;
    n_checks++;
    if (btn_event !== 4'h0) begin
      n_fail++; $display("FAIL ack_second_clear: event %h, want 0", btn_event);
    end
    btn_raw = 4'h1;
    tick(7);
  endtask

  task automatic test_release_bounce;
    for (int e = 1; e <= 14; e++) begin
      btn_raw = (e >= 5 && e <= 7) ? 4'h1 : 4'h0;
      tick(1);
      n_checks++;
      if (press_pulse !== 4'h0) begin
        n_fail++; $display("FAIL bounce_pulse edge %0d: pulse %h, want 0", e, press_pulse);
      end
      if (e == 7 || e == 13) begin
        n_checks++;
        if (btn_level !== 4'h1) begin
          n_fail++; $display("FAIL bounce_hold edge %0d: level %h, want 1", e, btn_level);
        end
      end
    end
    n_checks++;
    if (btn_level !== 4'h0 || pb_out !== 4'h0) begin
      n_fail++; $display("FAIL bounce_fall: level %h pb %h, want 0 0", btn_level, pb_out);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] exp_evt;
    btn_raw = 4'h2;
    tick(7);
    n_checks++;
    if (btn_level !== 4'h2) begin
      n_fail++; $display("FAIL areset_setup: level %h, want 2", btn_level);
    end
    btn_raw = 4'hA;
    tick(5);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({btn_level, press_pulse, btn_event, pb_out} !== 16'h0) begin
      n_fail++;
      $display("FAIL areset_immediate: got %h, want 0000", {btn_level, press_pulse, btn_event, pb_out});
    end
    tick(2);
    rst = 1'b0;
    tick(6);
    n_checks++;
    if (btn_level !== 4'h0) begin
      n_fail++; $display("FAIL areset_progress_lost: level %h, want 0", btn_level);
    end
    tick(1);
    exp_evt = STICKY ? 4'hA : 4'h0;
    n_checks++;
    if (btn_level !== 4'hA || press_pulse !== 4'hA || btn_event !== exp_evt || pb_out !== 4'hA) begin
      n_fail++;
      $display("FAIL areset_recommit: level %h pulse %h event %h pb %h, want A A %h A",
               btn_level, press_pulse, btn_event, pb_out, exp_evt);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_sticky_ack();
    test_release_bounce();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
